// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART FIFO slice.
package apb_uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef logic [$clog2(UART_FIFO_DEPTH):0] fifo_lvl_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic wm_hi;
    logic wm_lo;
    logic ovf;
    logic timeout;
  } fifo_status_t;

endpackage

// File: rtl/apb_uart_fifo_ptr.sv
// Pointer counter that wraps at DEPTH-1 back to 0, with enable and synchronous clear.
module apb_uart_fifo_ptr #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [PW-1:0] o_ptr
);

  localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/apb_uart_fifo_wm.sv
// UART data FIFO with watermarks and sticky overflow.
// Optional RX character timeout compiled in with APB_UART_FIFO_TIMEOUT_EN.
module apb_uart_fifo_wm
  import apb_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_W,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned LOG_DEPTH  = $clog2(DEPTH),
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [LOG_DEPTH:0]    level_o,
  output logic                  empty_o,
  output logic                  full_o,
  input  logic [LOG_DEPTH:0]    wm_hi_i,
  input  logic [LOG_DEPTH:0]    wm_lo_i,
  output logic                  wm_hi_o,
  output logic                  wm_lo_o,
  output logic                  ovf_o,
`ifdef APB_UART_FIFO_TIMEOUT_EN
  input  logic [TO_WIDTH-1:0]   timeout_val_i,
  output logic                  timeout_o,
`endif
  input  logic                  ovf_clr_i
);

  localparam logic [LOG_DEPTH:0] LP_DEPTH = (LOG_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LOG_DEPTH:0]    r_level;
  logic                  r_ovf;
  logic [LOG_DEPTH-1:0]  w_wr_ptr;
  logic [LOG_DEPTH-1:0]  w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);
  // No fall-through: a push into an empty FIFO never pops in the same cycle.
  assign w_push  = valid_i & ~w_full;
  assign w_pop   = ready_i & ~w_empty;

  apb_uart_fifo_ptr #(.DEPTH(DEPTH), .PW(LOG_DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clr_i),
    .i_en    (w_push),
    .o_ptr   (w_wr_ptr)
  );

  apb_uart_fifo_ptr #(.DEPTH(DEPTH), .PW(LOG_DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clr_i),
    .i_en    (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_push && !clr_i) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else if (clr_i) begin
      r_level <= '0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      r_level <= r_level - 1'b1;
    end
  end

  // Set beats ovf_clr_i when both occur in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_ovf <= 1'b0;
    end else if (valid_i && w_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef APB_UART_FIFO_TIMEOUT_EN
  logic [TO_WIDTH-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (clr_i || w_push || w_pop || w_empty) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt < timeout_val_i) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout_o = (timeout_val_i != '0) && (r_to_cnt == timeout_val_i);
`endif

  assign data_o  = r_mem[w_rd_ptr];
  assign level_o = r_level;
  assign empty_o = w_empty;
  assign full_o  = w_full;
  assign valid_o = ~w_empty;
  assign ready_o = ~w_full;
  assign ovf_o   = r_ovf;
  assign wm_hi_o = (wm_hi_i != '0) && (r_level >= wm_hi_i);
  assign wm_lo_o = (r_level <= wm_lo_i);

endmodule

// File: tb/tb_apb_uart_fifo_wm.sv
// Self-checking bench for apb_uart_fifo_wm (DEPTH 16); timeout checks only with APB_UART_FIFO_TIMEOUT_EN.
module tb_apb_uart_fifo_wm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr_i, valid_i, ready_i, ovf_clr_i;
  logic [7:0] data_i;
  logic       ready_o, valid_o, empty_o, full_o, wm_hi_o, wm_lo_o, ovf_o;
  logic [7:0] data_o;
  logic [4:0] level_o, wm_hi_i, wm_lo_i;
`ifdef APB_UART_FIFO_TIMEOUT_EN
  logic [15:0] timeout_val_i;
  logic        timeout_o;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  apb_uart_fifo_wm #(.DATA_WIDTH(8), .DEPTH(16), .TO_WIDTH(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clr_i         (clr_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .ready_i       (ready_i),
    .level_o       (level_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .wm_hi_i       (wm_hi_i),
    .wm_lo_i       (wm_lo_i),
    .wm_hi_o       (wm_hi_o),
    .wm_lo_o       (wm_lo_o),
    .ovf_o         (ovf_o),
`ifdef APB_UART_FIFO_TIMEOUT_EN
    .timeout_val_i (timeout_val_i),
    .timeout_o     (timeout_o),
`endif
    .ovf_clr_i     (ovf_clr_i)
  );

  typedef struct {
    logic       clr, vld;
    logic [7:0] din;
    logic       rdy, oclr;
    logic [4:0] whi, wlo;
    logic [4:0] lvl;
    logic       val, full, empty, ovf, hi, lo;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i = 0; valid_i = 0; ready_i = 0; ovf_clr_i = 0; data_i = '0;
  endtask

  task automatic push(input logic [7:0] d);
    valid_i = 1; data_i = d; step(); valid_i = 0;
  endtask

  task automatic pop();
    ready_i = 1; step(); ready_i = 0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    int unsigned lvl;

    idle_inputs();
    reset_n = 0; wm_hi_i = 5'd4; wm_lo_i = 5'd2;
`ifdef APB_UART_FIFO_TIMEOUT_EN
    timeout_val_i = 16'd10;
`endif
    #22 reset_n = 1;
    step();

    check("rst_level", level_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_empty", empty_o, 1);
    check("rst_full",  full_o, 0);
    check("rst_ovf",   ovf_o, 0);
    check("rst_wmlo",  wm_lo_o, 1);
    check("rst_wmhi",  wm_hi_o, 0);

    //          clr vld din    rdy oclr whi wlo  lvl val full emp ovf hi lo dout
    vecs[0]  = '{0, 1, 8'h11, 0, 0, 4, 2,  1, 1, 0, 0, 0, 0, 1, 8'h11};
    vecs[1]  = '{0, 1, 8'h22, 0, 0, 4, 2,  2, 1, 0, 0, 0, 0, 1, 8'h11};
    vecs[2]  = '{0, 1, 8'h33, 0, 0, 4, 2,  3, 1, 0, 0, 0, 0, 0, 8'h11};
    vecs[3]  = '{0, 1, 8'h44, 0, 0, 4, 2,  4, 1, 0, 0, 0, 1, 0, 8'h11};
    vecs[4]  = '{0, 0, 8'h00, 1, 0, 4, 2,  3, 1, 0, 0, 0, 0, 0, 8'h22};
    vecs[5]  = '{0, 0, 8'h00, 1, 0, 4, 2,  2, 1, 0, 0, 0, 0, 1, 8'h33};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 4, 2,  1, 1, 0, 0, 0, 0, 1, 8'h44};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 4, 2,  0, 0, 0, 1, 0, 0, 1, 8'h00};
    vecs[8]  = '{0, 1, 8'h55, 1, 0, 4, 2,  1, 1, 0, 0, 0, 0, 1, 8'h55};
    vecs[9]  = '{0, 1, 8'h66, 1, 0, 4, 2,  1, 1, 0, 0, 0, 0, 1, 8'h66};
    vecs[10] = '{0, 0, 8'h00, 1, 0, 4, 2,  0, 0, 0, 1, 0, 0, 1, 8'h00};
    vecs[11] = '{0, 1, 8'h77, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0, 1, 8'h77};
    vecs[12] = '{0, 1, 8'h88, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 8'h77};
    vecs[13] = '{1, 1, 8'h99, 1, 0, 4, 2,  0, 0, 0, 1, 0, 0, 1, 8'h00};

    for (int i = 0; i < 14; i++) begin
      clr_i = vecs[i].clr; valid_i = vecs[i].vld; data_i = vecs[i].din;
      ready_i = vecs[i].rdy; ovf_clr_i = vecs[i].oclr;
      wm_hi_i = vecs[i].whi; wm_lo_i = vecs[i].wlo;
      step();
      check($sformatf("v%0d_level", i), level_o, vecs[i].lvl);
      check($sformatf("v%0d_valid", i), valid_o, vecs[i].val);
      check($sformatf("v%0d_full", i),  full_o,  vecs[i].full);
      check($sformatf("v%0d_empty", i), empty_o, vecs[i].empty);
      check($sformatf("v%0d_ovf", i),   ovf_o,   vecs[i].ovf);
      check($sformatf("v%0d_wmhi", i),  wm_hi_o, vecs[i].hi);
      check($sformatf("v%0d_wmlo", i),  wm_lo_o, vecs[i].lo);
      if (vecs[i].val) check($sformatf("v%0d_data", i), data_o, vecs[i].dout);
    end
    idle_inputs(); wm_hi_i = 5'd4; wm_lo_i = 5'd2;

    // Fill past full: 16th push sets full, 17th is rejected and flags overflow.
    for (int i = 0; i < 17; i++) begin
      push(8'hA0 + 8'(i));
      check($sformatf("fill%0d_level", i), level_o, (i < 16) ? i + 1 : 16);
      check($sformatf("fill%0d_full", i), full_o, (i >= 15) ? 1 : 0);
      check($sformatf("fill%0d_ovf", i), ovf_o, (i == 16) ? 1 : 0);
    end
    check("fill_head", data_o, 8'hA0);
    ovf_clr_i = 1; step(); ovf_clr_i = 0;
    check("ovfclr_ovf", ovf_o, 0);
    check("ovfclr_level", level_o, 16);

    // Overflow set and clear in the same cycle: set wins.
    valid_i = 1; data_i = 8'hEE; ovf_clr_i = 1; step(); idle_inputs();
    check("setwins_ovf", ovf_o, 1);
    ovf_clr_i = 1; step(); ovf_clr_i = 0;
    check("setwins_clr", ovf_o, 0);

    // Full with simultaneous push and pop: pop only, push rejected.
    valid_i = 1; data_i = 8'hBB; ready_i = 1; step(); idle_inputs();
    check("fullpp_level", level_o, 15);
    check("fullpp_ovf", ovf_o, 1);
    check("fullpp_head", data_o, 8'hA1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d_data", i), data_o, 8'hA0 + 8'(i));
      pop();
    end
    check("drain_empty", empty_o, 1);
    ovf_clr_i = 1; step(); ovf_clr_i = 0;

    // 20 pushes and 20 pops overlapping, crossing the pointer wrap.
    q.delete();
    for (int k = 0; k < 40; k++) begin
      valid_i = (k < 20);
      d = 8'(8'h30 + k * 7);
      data_i = d;
      ready_i = (k >= 6);
      if (q.size() != 0) check($sformatf("wrap%0d_data", k), data_o, q[0]);
      lvl = q.size();
      if (ready_i && lvl != 0) void'(q.pop_front());
      if (valid_i && lvl != 16) q.push_back(d);
      step();
      check($sformatf("wrap%0d_level", k), level_o, q.size());
    end
    idle_inputs();
    check("wrap_empty", empty_o, 1);

    // Flush with 5 entries and overflow set.
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int i = 0; i < 11; i++) pop();
    check("preclr_level", level_o, 5);
    check("preclr_ovf", ovf_o, 1);
    clr_i = 1; valid_i = 1; ready_i = 1; data_i = 8'hCC; step(); idle_inputs();
    check("clr_level", level_o, 0);
    check("clr_empty", empty_o, 1);
    check("clr_ovf", ovf_o, 0);
    push(8'h3C);
    check("postclr_data", data_o, 8'h3C);
    check("postclr_level", level_o, 1);
    pop();

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 16; i++) push(8'h70 + 8'(i));
    valid_i = 1; data_i = 8'hFF; step(); valid_i = 0;
    #2 reset_n = 0;
    #1;
    check("arst_level", level_o, 0);
    check("arst_empty", empty_o, 1);
    check("arst_ovf", ovf_o, 0);
    @(negedge clk); reset_n = 1;
    step();
    push(8'h5A);
    check("postrst_data", data_o, 8'h5A);
    check("postrst_level", level_o, 1);
    pop();

`ifdef APB_UART_FIFO_TIMEOUT_EN
    timeout_val_i = 16'd10;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("to_empty%0d", k), timeout_o, 0);
    end
    push(8'h42);
    check("to_push", timeout_o, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("to_idle%0d", k), timeout_o, (k >= 10) ? 1 : 0);
    end
    pop();
    check("to_pop", timeout_o, 0);
    for (int k = 0; k < 12; k++) step();
    check("to_empty_after", timeout_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_uart_fifo_wm.md
Name: apb_uart_fifo_wm

Overview:
Next-generation UART data FIFO for the APB UART RX and TX paths. It keeps the valid/ready push/pop interface and adds programmable watermarks, a sticky overflow flag, and an optional RX character-timeout counter. It sits between the UART shift logic and the APB register file, which reads the level, threshold and status outputs for interrupt generation.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry.
DEPTH, 16, number of entries; any value >= 2, power of two not required.
LOG_DEPTH, $clog2(DEPTH), pointer width; level/threshold fields are LOG_DEPTH+1 bits.
TO_WIDTH, 16, width of the timeout counter and timeout_val_i.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clr_i  in  1  synchronous flush: empties FIFO, clears sticky flags and timeout
valid_i  in  1  push request
data_i  in  DATA_WIDTH  push data
ready_o  out  1  not full (= ~full_o)
valid_o  out  1  not empty
data_o  out  DATA_WIDTH  head entry, combinational from storage
ready_i  in  1  pop request
level_o  out  LOG_DEPTH+1  current occupancy 0..DEPTH
empty_o  out  1  level_o == 0
full_o  out  1  level_o == DEPTH
wm_hi_i  in  LOG_DEPTH+1  high watermark, RX trigger level
wm_lo_i  in  LOG_DEPTH+1  low watermark, TX refill level
wm_hi_o  out  1  level_o >= wm_hi_i and wm_hi_i != 0
wm_lo_o  out  1  level_o <= wm_lo_i
ovf_o  out  1  sticky: push attempted while full
ovf_clr_i  in  1  clears ovf_o
timeout_val_i  in  TO_WIDTH  idle cycles before timeout (compiled only with the optional feature)
timeout_o  out  1  character timeout (compiled only with the optional feature)

Behaviour:
- Reset (reset_n low, asynchronous): pointers = 0, level = 0, ovf_o = 0, timeout counter = 0, timeout_o = 0. Storage is not reset.
- Reset-derived outputs: valid_o = 0, ready_o = 1, empty_o = 1, full_o = 0. wm_lo_o = 1; wm_hi_o = 0 unless wm_hi_i == 0 (then also 0).
- push = valid_i & ~full_o; pop = ready_i & valid_o. Both are evaluated on the pre-edge state.
- Push writes data_i at wr_ptr; wr_ptr wraps DEPTH-1 -> 0. Pop advances rd_ptr with the same wrap rule.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with pop and valid_i in the same cycle: pop is taken, push is rejected, ovf_o is set, level becomes DEPTH-1. There is no fall-through.
- Empty with valid_i and ready_i: push is taken, no pop occurs; data appears on data_o the next cycle. Read latency is 1 cycle from push to valid_o.
- Overflow: valid_i & full_o sets ovf_o on the next edge. ovf_clr_i or clr_i clears it. If set and clear occur in the same cycle, set wins.
- clr_i has priority over push and pop: pointers, level, ovf_o and timeout all go to 0.
- Watermark outputs are combinational from the level register and live inputs. No hysteresis.
- All arithmetic is unsigned, LOG_DEPTH+1 bits, with no overflow possible.

Optional Feature:
Macro: APB_UART_FIFO_TIMEOUT_EN.
Defined:
- Timeout counter increments each cycle that valid_o = 1, push = 0 and pop = 0.
- Counter resets to 0 on any push, any pop, clr_i, or when the FIFO is empty.
- Counter saturates at timeout_val_i.
- timeout_o = 1 while counter == timeout_val_i and timeout_val_i != 0. It therefore asserts exactly timeout_val_i idle cycles after the last activity.
Undefined:
- timeout_val_i and timeout_o ports are absent and no counter logic is generated.

Decomposition:
- Shared package apb_uart_pkg holds: UART_DATA_W = 8; UART_FIFO_DEPTH = 16; typedef fifo_lvl_t (logic [$clog2(UART_FIFO_DEPTH):0]); typedef fifo_status_t (packed struct: empty, full, wm_hi, wm_lo, ovf, timeout).
- Sub-module apb_uart_fifo_ptr: wrap-at-DEPTH pointer counter with enable and clear, instanced twice for read and write pointers.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 with ready_i = 0, then pop three -> level 1,2,3 then 2,1,0; data_o order 0x11,0x22,0x33; valid_o falls after the third pop.
2. DEPTH = 16: push 17 bytes -> full_o on the 16th; the 17th is rejected, ovf_o = 1, level = 16. Then ovf_clr_i -> ovf_o = 0.
3. Full, then simultaneous valid_i and ready_i -> level 15, ovf_o = 1, head advances; push 20 and pop 20 across wrap -> data intact, in order.
4. wm_hi_i = 4, wm_lo_i = 2: push 4 -> wm_hi_o rises on the 4th push edge; pop to 2 -> wm_lo_o = 1, wm_hi_o = 0. With wm_hi_i = 0 -> wm_hi_o stays 0.
5. clr_i with 5 entries and ovf_o set; separately, reset_n low mid-burst -> next cycle level 0, empty_o 1, ovf_o 0; the next push reads back correctly.
6. TIMEOUT_EN, timeout_val_i = 10: push 1 byte then idle -> timeout_o high exactly 10 cycles after the push; a pop clears it the next cycle; an empty FIFO never times out.
